irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Interrupt controller sitting directly downstream of the timer and the other bus devices in the MIPS microsystem.
- Collects device IRQ lines (timer IRQ pulses included), latches them into a pending register and applies a mask and fixed priority.
- Presents one request plus a source ID to the CPU exception logic, with an acknowledge / end-of-interrupt handshake.
- Software-visible through the same word-addressed bus slave interface as the other devices.

Parameters:
- N_SRC, 6: number of interrupt sources, 1..8. Source 0 has the highest priority.

Ports:
- CLK_I  input  1  system clock; all state updates on the rising edge.
- RST_I  input  1  reset, asynchronous, active-low.
- ADD_I  input  2 ([3:2])  register select: 0 PENDING, 1 MASK, 2 MODE, 3 STATUS.
- WE_I  input  1  bus write enable.
- DAT_I  input  32  bus write data.
- DAT_O  output  32  bus read data, combinational on ADD_I.
- IRQ_SRC_I  input  N_SRC  device interrupt lines; bit 0 is the timer.
- INT_ACK_I  input  1  one-cycle pulse from the CPU when it takes the interrupt.
- INT_REQ_O  output  1  interrupt request to the CPU, registered.
- INT_ID_O  output  3  index of the source being requested or serviced, registered.

Behaviour:
- Reset (RST_I=0, takes effect immediately, no clock needed):
  - PENDING=0, MASK=0, MODE=all ones (edge), prev-sample register=0.
  - state=IDLE, INT_REQ_O=0, INT_ID_O=0.
- Sampling: prev[i] is updated from IRQ_SRC_I[i] every cycle.
- Edge-mode source (MODE[i]=1):
  - rise = IRQ_SRC_I[i] & ~prev[i].
  - A rise sets PENDING[i] at that clock edge, so a single-cycle timer pulse is caught.
  - PENDING[i] is cleared by a write to ADD_I=0 with DAT_I[i]=1 (write-1-to-clear), or automatically on acknowledge of source i.
  - If a set and a clear occur in the same cycle, the set wins.
- Level-mode source (MODE[i]=0): PENDING[i] <= IRQ_SRC_I[i] every cycle; W1C and ack-clear have no effect.
- Writes:
  - MASK: bits [N_SRC-1:0] are loaded from DAT_I.
  - MODE: bits [N_SRC-1:0] are loaded from DAT_I.
  - Upper bits are ignored and read back as 0.
- active = PENDING & MASK. Priority encode lowest set index → sel.
- State machine (encoding 00 IDLE, 01 REQ, 10 SERVICE):
  - IDLE: if active≠0 → REQ; INT_ID_O<=sel; INT_REQ_O<=1.
  - REQ:
    - INT_REQ_O stays 1 and INT_ID_O is held; a higher-priority arrival does NOT preempt.
    - If INT_ACK_I=1 → SERVICE; INT_REQ_O<=0; ack-clear PENDING[INT_ID_O] if edge mode.
    - Else if active[INT_ID_O]=0 (masked or level dropped) → IDLE; INT_REQ_O<=0. Withdrawal.
  - SERVICE:
    - INT_REQ_O=0. New pendings accumulate but are not requested.
    - A write to ADD_I=3 with DAT_I[0]=1 (EOI) → IDLE.
    - INT_ACK_I is ignored in IDLE and SERVICE.
- Latency: source rise sampled at edge k → PENDING set at k → REQ and INT_REQ_O=1 after edge k+1, provided the source is unmasked and state was IDLE.
- After EOI: if active≠0, REQ is re-entered one cycle later (IDLE for exactly one cycle).
- A MASK write and an IDLE/REQ evaluation in the same cycle use the old MASK value.
- DAT_O:
  - 0 → PENDING, zero-extended.
  - 1 → MASK.
  - 2 → MODE.
  - 3 → {INT_REQ_O, 21'b0, state[1:0], 5'b0, INT_ID_O}, i.e. [31] request, [9:8] state, [2:0] ID.
- Reset while in REQ or SERVICE: INT_REQ_O drops asynchronously and all pending is lost.

Test Plan:
- Reset: RST_I=0 mid-REQ → INT_REQ_O=0 immediately; after release, read STATUS=0x00000000, MODE=0x3F, MASK=0.
- Timer pulse: MASK=0x01, one-cycle IRQ_SRC_I[0] pulse at edge k → PENDING=0x01 at k, INT_REQ_O=1 and INT_ID_O=0 after k+1; INT_ACK_I pulse → PENDING=0, STATUS[9:8]=2; write STATUS=1 → STATUS[9:8]=0.
- Priority/no preempt: MASK=0x3F, source 3 edge, REQ with ID=3, then source 1 edge → ID stays 3; ack, EOI → one IDLE cycle, then REQ with ID=1.
- Masking: source 2 pending with MASK=0 → no request; MASK=0x04 → INT_REQ_O=1 one cycle later; MASK=0 written while in REQ → back to IDLE, INT_REQ_O=0, PENDING still 0x04.
- W1C vs edge collision: PENDING[4]=1, W1C bit 4 in the same cycle as a new rise on source 4 → PENDING[4] stays 1.
- Level mode: MODE=0x00, MASK=0x02, IRQ_SRC_I[1] held high → REQ with ID=1; drop input before ack → withdraws to IDLE; W1C of bit 1 while input high → PENDING[1] stays 1.

Source files
------------

// File: rtl/irq_controller.sv
// Interrupt controller: latches device IRQ lines into PENDING, applies MASK and
// fixed priority (source 0 highest), and drives one request/ID to the CPU.
module irq_controller #(
    parameter int unsigned N_SRC = 6
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic [3:2]       ADD_I,
    input  logic             WE_I,
    input  logic [31:0]      DAT_I,
    output logic [31:0]      DAT_O,
    input  logic [N_SRC-1:0] IRQ_SRC_I,
    input  logic             INT_ACK_I,
    output logic             INT_REQ_O,
    output logic [2:0]       INT_ID_O
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        SERVICE = 2'b10
    } state_t;

    state_t           state, state_nxt;
    logic [N_SRC-1:0] pending, mask, mode, prev;
    logic [N_SRC-1:0] pending_nxt, rise, w1c, ack_clr, active;
    logic [7:0]       active_w;
    logic [2:0]       sel, int_id_nxt;
    logic             any_active, int_req_nxt;
    logic             wr_pend, wr_mask, wr_mode, eoi;

    assign wr_pend  = WE_I && (ADD_I == 2'd0);
    assign wr_mask  = WE_I && (ADD_I == 2'd1);
    assign wr_mode  = WE_I && (ADD_I == 2'd2);
    assign eoi      = WE_I && (ADD_I == 2'd3) && DAT_I[0];

    assign rise     = IRQ_SRC_I & ~prev;
    assign w1c      = wr_pend ? DAT_I[N_SRC-1:0] : '0;
    assign active   = pending & mask;
    assign active_w = 8'(active);

    always_comb begin
        ack_clr = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            ack_clr[i] = (state == REQ) && INT_ACK_I && (INT_ID_O == 3'(i));
        end
    end

    // Edge sources: a new rise beats a same-cycle clear. Level sources track the line.
    assign pending_nxt = (mode & (rise | (pending & ~(w1c | ack_clr))))
                       | (~mode & IRQ_SRC_I);

    always_comb begin
        sel        = '0;
        any_active = 1'b0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (active[i] && !any_active) begin
                sel        = 3'(i);
                any_active = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        int_req_nxt = INT_REQ_O;
        int_id_nxt  = INT_ID_O;
        case (state)
            IDLE: begin
                if (any_active) begin
                    state_nxt   = REQ;
                    int_req_nxt = 1'b1;
                    int_id_nxt  = sel;
                end
            end
            REQ: begin
                if (INT_ACK_I) begin
                    state_nxt   = SERVICE;
                    int_req_nxt = 1'b0;
                end else if (!active_w[INT_ID_O]) begin
                    state_nxt   = IDLE;
                    int_req_nxt = 1'b0;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt   = IDLE;
                int_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            pending   <= '0;
            mask      <= '0;
            mode      <= '1;
            prev      <= '0;
            state     <= IDLE;
            INT_REQ_O <= 1'b0;
            INT_ID_O  <= '0;
        end else begin
            prev      <= IRQ_SRC_I;
            pending   <= pending_nxt;
            if (wr_mask) mask <= DAT_I[N_SRC-1:0];
            if (wr_mode) mode <= DAT_I[N_SRC-1:0];
            state     <= state_nxt;
            INT_REQ_O <= int_req_nxt;
            INT_ID_O  <= int_id_nxt;
        end
    end

    always_comb begin
        DAT_O = '0;
        case (ADD_I)
            2'd0:    DAT_O = 32'(pending);
            2'd1:    DAT_O = 32'(mask);
            2'd2:    DAT_O = 32'(mode);
            default: DAT_O = {INT_REQ_O, 21'b0, state, 5'b0, INT_ID_O};
        endcase
    end

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: expectations queued as stimulus is
// driven, observations queued as the DUT responds, compared at task end.
module tb_irq_controller;

    localparam int unsigned N = 6;

    logic          CLK_I;
    logic          RST_I;
    logic [3:2]    ADD_I;
    logic          WE_I;
    logic [31:0]   DAT_I;
    logic [31:0]   DAT_O;
    logic [N-1:0]  IRQ_SRC_I;
    logic          INT_ACK_I;
    logic          INT_REQ_O;
    logic [2:0]    INT_ID_O;

    typedef struct {
        string       name;
        logic [31:0] val;
    } sb_t;

    sb_t         exp_q[$];
    sb_t         obs_q[$];
    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    irq_controller #(.N_SRC(N)) dut (
        .CLK_I     (CLK_I),
        .RST_I     (RST_I),
        .ADD_I     (ADD_I),
        .WE_I      (WE_I),
        .DAT_I     (DAT_I),
        .DAT_O     (DAT_O),
        .IRQ_SRC_I (IRQ_SRC_I),
        .INT_ACK_I (INT_ACK_I),
        .INT_REQ_O (INT_REQ_O),
        .INT_ID_O  (INT_ID_O)
    );

    initial begin
        CLK_I = 1'b0;
        forever #5 CLK_I = ~CLK_I;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        ADD_I = a;
        DAT_I = d;
        WE_I  = 1'b1;
        tick();
        WE_I  = 1'b0;
        DAT_I = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        ADD_I = a;
        WE_I  = 1'b0;
        #1;
        d = DAT_O;
    endtask

    task automatic expect_v(input string nm, input logic [31:0] v);
        exp_q.push_back('{nm, v});
    endtask

    task automatic observe(input string nm, input logic [31:0] v);
        obs_q.push_back('{nm, v});
    endtask

    task automatic do_reset();
        WE_I      = 1'b0;
        INT_ACK_I = 1'b0;
        IRQ_SRC_I = '0;
        ADD_I     = 2'd0;
        DAT_I     = '0;
        RST_I     = 1'b0;
        tick();
        RST_I     = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        sb_t e, o;
        do_reset();
        wr(2'd1, 32'h1);
        expect_v("req_before_rst", 32'h1);
        IRQ_SRC_I = 6'h01; tick();
        IRQ_SRC_I = '0;    tick();
        observe("req_before_rst", {31'b0, INT_REQ_O});
        expect_v("req_async_drop", 32'h0);
        expect_v("id_async_drop", 32'h0);
        RST_I = 1'b0;
        #1;
        observe("req_async_drop", {31'b0, INT_REQ_O});
        observe("id_async_drop", {29'b0, INT_ID_O});
        RST_I = 1'b1;
        expect_v("rst_status", 32'h0);
        expect_v("rst_mode", 32'h3F);
        expect_v("rst_mask", 32'h0);
        expect_v("rst_pending", 32'h0);
        rd(2'd3, d); observe("rst_status", d);
        rd(2'd2, d); observe("rst_mode", d);
        rd(2'd1, d); observe("rst_mask", d);
        rd(2'd0, d); observe("rst_pending", d);
        expect_v("mask_upper_bits", 32'h3F);
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1, d); observe("mask_upper_bits", d);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (obs_q.size() == 0) $display("FAIL %s: got nothing want %h", e.name, e.val);
            else begin
                o = obs_q.pop_front();
                if (o.val !== e.val) $display("FAIL %s: got %h want %h", e.name, o.val, e.val);
                else n_pass++;
            end
        end
        obs_q.delete();
    endtask

    task automatic test_timer_pulse();
        logic [31:0] d;
        sb_t e, o;
        do_reset();
        wr(2'd1, 32'h01);
        expect_v("tmr_pending_k", 32'h01);
        expect_v("tmr_req_k", 32'h0);
        IRQ_SRC_I = 6'h01; tick();
        rd(2'd0, d); observe("tmr_pending_k", d);
        observe("tmr_req_k", {31'b0, INT_REQ_O});
        expect_v("tmr_req_k1", 32'h1);
        expect_v("tmr_id_k1", 32'h0);
        IRQ_SRC_I = '0; tick();
        observe("tmr_req_k1", {31'b0, INT_REQ_O});
        observe("tmr_id_k1", {29'b0, INT_ID_O});
        expect_v("tmr_pending_ack", 32'h0);
        expect_v("tmr_status_svc", 32'h0000_0200);
        INT_ACK_I = 1'b1; tick();
        INT_ACK_I = 1'b0;
        rd(2'd0, d); observe("tmr_pending_ack", d);
        rd(2'd3, d); observe("tmr_status_svc", d);
        expect_v("tmr_status_eoi", 32'h0);
        wr(2'd3, 32'h1);
        rd(2'd3, d); observe("tmr_status_eoi", d);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (obs_q.size() == 0) $display("FAIL %s: got nothing want %h", e.name, e.val);
            else begin
                o = obs_q.pop_front();
                if (o.val !== e.val) $display("FAIL %s: got %h want %h", e.name, o.val, e.val);
                else n_pass++;
            end
        end
        obs_q.delete();
    endtask

    task automatic test_priority();
        logic [31:0] d;
        sb_t e, o;
        do_reset();
        wr(2'd1, 32'h3F);
        expect_v("pri_status_req3", 32'h8000_0103);
        IRQ_SRC_I = 6'h08; tick();
        IRQ_SRC_I = '0;    tick();
        rd(2'd3, d); observe("pri_status_req3", d);
        expect_v("pri_no_preempt", 32'h8000_0103);
        expect_v("pri_pending_both", 32'h0A);
        IRQ_SRC_I = 6'h02; tick();
        IRQ_SRC_I = '0;    tick();
        rd(2'd3, d); observe("pri_no_preempt", d);
        rd(2'd0, d); observe("pri_pending_both", d);
        expect_v("pri_pending_ack", 32'h02);
        expect_v("pri_status_svc", 32'h0000_0203);
        INT_ACK_I = 1'b1; tick();
        INT_ACK_I = 1'b0;
        rd(2'd0, d); observe("pri_pending_ack", d);
        rd(2'd3, d); observe("pri_status_svc", d);
        expect_v("pri_ack_in_svc_pend", 32'h02);
        expect_v("pri_ack_in_svc_stat", 32'h0000_0203);
        INT_ACK_I = 1'b1; tick();
        INT_ACK_I = 1'b0; tick();
        rd(2'd0, d); observe("pri_ack_in_svc_pend", d);
        rd(2'd3, d); observe("pri_ack_in_svc_stat", d);
        expect_v("pri_idle_one_cycle", 32'h0000_0003);
        wr(2'd3, 32'h1);
        rd(2'd3, d); observe("pri_idle_one_cycle", d);
        expect_v("pri_status_req1", 32'h8000_0101);
        tick();
        rd(2'd3, d); observe("pri_status_req1", d);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (obs_q.size() == 0) $display("FAIL %s: got nothing want %h", e.name, e.val);
            else begin
                o = obs_q.pop_front();
                if (o.val !== e.val) $display("FAIL %s: got %h want %h", e.name, o.val, e.val);
                else n_pass++;
            end
        end
        obs_q.delete();
    endtask

    task automatic test_masking();
        logic [31:0] d;
        sb_t e, o;
        do_reset();
        expect_v("msk_req_masked", 32'h0);
        expect_v("msk_pending", 32'h04);
        IRQ_SRC_I = 6'h04; tick();
        IRQ_SRC_I = '0;    tick();
        tick();
        observe("msk_req_masked", {31'b0, INT_REQ_O});
        rd(2'd0, d); observe("msk_pending", d);
        expect_v("msk_old_mask_used", 32'h0);
        wr(2'd1, 32'h04);
        observe("msk_old_mask_used", {31'b0, INT_REQ_O});
        expect_v("msk_req_unmasked", 32'h1);
        expect_v("msk_id", 32'h2);
        tick();
        observe("msk_req_unmasked", {31'b0, INT_REQ_O});
        observe("msk_id", {29'b0, INT_ID_O});
        expect_v("msk_req_hold_same_cycle", 32'h1);
        wr(2'd1, 32'h0);
        observe("msk_req_hold_same_cycle", {31'b0, INT_REQ_O});
        expect_v("msk_withdraw_req", 32'h0);
        expect_v("msk_withdraw_status", 32'h0000_0002);
        expect_v("msk_pending_kept", 32'h04);
        tick();
        observe("msk_withdraw_req", {31'b0, INT_REQ_O});
        rd(2'd3, d); observe("msk_withdraw_status", d);
        rd(2'd0, d); observe("msk_pending_kept", d);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (obs_q.size() == 0) $display("FAIL %s: got nothing want %h", e.name, e.val);
            else begin
                o = obs_q.pop_front();
                if (o.val !== e.val) $display("FAIL %s: got %h want %h", e.name, o.val, e.val);
                else n_pass++;
            end
        end
        obs_q.delete();
    endtask

    task automatic test_w1c_collision();
        logic [31:0] d;
        sb_t e, o;
        do_reset();
        expect_v("col_pending_set", 32'h10);
        IRQ_SRC_I = 6'h10; tick();
        IRQ_SRC_I = '0;    tick();
        rd(2'd0, d); observe("col_pending_set", d);
        expect_v("col_set_wins", 32'h10);
        IRQ_SRC_I = 6'h10;
        wr(2'd0, 32'h10);
        rd(2'd0, d); observe("col_set_wins", d);
        expect_v("col_w1c_clears", 32'h0);
        IRQ_SRC_I = '0;
        wr(2'd0, 32'h10);
        rd(2'd0, d); observe("col_w1c_clears", d);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (obs_q.size() == 0) $display("FAIL %s: got nothing want %h", e.name, e.val);
            else begin
                o = obs_q.pop_front();
                if (o.val !== e.val) $display("FAIL %s: got %h want %h", e.name, o.val, e.val);
                else n_pass++;
            end
        end
        obs_q.delete();
    endtask

    task automatic test_level();
        logic [31:0] d;
        sb_t e, o;
        do_reset();
        wr(2'd2, 32'h00);
        wr(2'd1, 32'h02);
        expect_v("lvl_status_req1", 32'h8000_0101);
        IRQ_SRC_I = 6'h02; tick();
        tick();
        rd(2'd3, d); observe("lvl_status_req1", d);
        expect_v("lvl_withdraw_req", 32'h0);
        expect_v("lvl_withdraw_status", 32'h0000_0001);
        IRQ_SRC_I = '0; tick();
        tick();
        observe("lvl_withdraw_req", {31'b0, INT_REQ_O});
        rd(2'd3, d); observe("lvl_withdraw_status", d);
        expect_v("lvl_w1c_no_effect", 32'h02);
        IRQ_SRC_I = 6'h02; tick();
        wr(2'd0, 32'h02);
        rd(2'd0, d); observe("lvl_w1c_no_effect", d);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (obs_q.size() == 0) $display("FAIL %s: got nothing want %h", e.name, e.val);
            else begin
                o = obs_q.pop_front();
                if (o.val !== e.val) $display("FAIL %s: got %h want %h", e.name, o.val, e.val);
                else n_pass++;
            end
        end
        obs_q.delete();
    endtask

    initial begin
        RST_I     = 1'b0;
        WE_I      = 1'b0;
        INT_ACK_I = 1'b0;
        IRQ_SRC_I = '0;
        ADD_I     = 2'd0;
        DAT_I     = '0;
        test_reset();
        test_timer_pulse();
        test_priority();
        test_masking();
        test_w1c_collision();
        test_level();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
